// File: rtl/uart_rx.sv
// 8N1-style UART receiver with 2-flop input synchronizer and oversampled bit timing.
// Delivers each received word with a one-cycle done strobe and flags framing errors and false starts.
module uart_rx #(
   parameter int OVS   = 16,
   parameter int DBITS = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             rxd,
   input  logic             rxen,
   output logic [DBITS-1:0] rx_data,
   output logic             rx_done,
   output logic             frame_err,
   output logic             busy
);

   localparam int TW = $clog2(OVS);
   localparam int BW = $clog2(DBITS);

   // START is entered on the tick after the falling edge was seen, so the midpoint
   // tick of the start bit is reached one count earlier than in DATA/STOP.
   localparam logic [TW-1:0] TICK_MID  = TW'(OVS / 2 - 2);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DBITS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BRK   = 3'd4
   } state_t;

   state_t           state_q;
   logic             rxMeta_q;
   logic             rxs_q;
   logic [TW-1:0]    tick_q;
   logic [BW-1:0]    bit_q;
   logic [DBITS-1:0] shift_q;
   logic [DBITS-1:0] rxData_q;
   logic             rxDone_q;
   logic             frameErr_q;
   logic             busy_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rxMeta_q <= 1'b1;
         rxs_q    <= 1'b1;
      end else begin
         rxMeta_q <= rxd;
         rxs_q    <= rxMeta_q;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         tick_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         rxData_q   <= '0;
         rxDone_q   <= 1'b0;
         frameErr_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         rxDone_q   <= 1'b0;
         frameErr_q <= 1'b0;
         if (rxen) begin
            case (state_q)
               IDLE: begin
                  if (!rxs_q) begin
                     state_q <= START;
                     tick_q  <= '0;
                     busy_q  <= 1'b1;
                  end
               end
               START: begin
                  if (tick_q == TICK_MID) begin
                     if (!rxs_q) begin
                        state_q <= DATA;
                        tick_q  <= '0;
                        bit_q   <= '0;
                     end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
               DATA: begin
                  if (tick_q == TICK_LAST) begin
                     shift_q <= {rxs_q, shift_q[DBITS-1:1]};
                     tick_q  <= '0;
                     bit_q   <= bit_q + 1'b1;
                     if (bit_q == BIT_LAST) begin
                        state_q <= STOP;
                     end
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
               STOP: begin
                  if (tick_q == TICK_LAST) begin
                     tick_q <= '0;
                     if (rxs_q) begin
                        rxData_q <= shift_q;
                        rxDone_q <= 1'b1;
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                     end else begin
                        frameErr_q <= 1'b1;
                        state_q    <= BRK;
                     end
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
               // A held-low line must return high before another start can be detected.
               BRK: begin
                  if (rxs_q) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end else if (state_q > BRK) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end
      end
   end

   assign rx_data   = rxData_q;
   assign rx_done   = rxDone_q;
   assign frame_err = frameErr_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (OVS=16, DBITS=8).
// Frames are serialized on negedges; DUT outputs are sampled on negedges.
module tb_uart_rx;

   logic       clk;
   logic       n_rst;
   logic       rxd;
   logic       rxen;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;
   logic       busy;

   int compared   = 0;
   int mismatched = 0;

   int tickPeriod = 1;
   int divCnt     = 0;
   logic rxenGate = 1'b1;

   int cyc         = 0;
   int doneCnt     = 0;
   int frameErrCnt = 0;
   int bothHigh    = 0;
   int doneCyc     = 0;
   int startCyc    = 0;

   uart_rx #(.OVS(16), .DBITS(8)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .rxd       (rxd),
      .rxen      (rxen),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Oversample tick generator: one pulse every tickPeriod clocks while enabled.
   always @(negedge clk) begin
      if (rxenGate) begin
         rxen = (divCnt == 0);
         divCnt = (divCnt + 1) % tickPeriod;
      end else begin
         rxen = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rx_done) begin
         doneCnt++;
         doneCyc = cyc;
      end
      if (frame_err) frameErrCnt++;
      if (rx_done && frame_err) bothHigh++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic sendBit(input logic b, input int clks);
      rxd = b;
      repeat (clks) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int clks);
      sendBit(1'b0, clks);
      for (int i = 0; i < 8; i++) sendBit(data[i], clks);
      sendBit(stopBit, clks);
   endtask

   initial begin
      logic [7:0] gated;
      logic [7:0] second;
      n_rst = 1'b0;
      rxd   = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_rx_data", 32'(rx_data), 32'h0);
      checkOutput("reset_rx_done", 32'(rx_done), 32'h0);
      checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
      checkOutput("reset_busy", 32'(busy), 32'h0);
      n_rst = 1'b1;
      repeat (5) @(negedge clk);

      $display("[TB] single byte 0xA5, rxen every clk");
      rxd = 1'b0;
      startCyc = cyc;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) sendBit(8'hA5 >> i, 16);
      checkOutput("a5_busy_mid", 32'(busy), 32'h1);
      sendBit(1'b1, 16);
      sendBit(1'b1, 16);
      checkOutput("a5_done_count", 32'(doneCnt), 32'd1);
      checkOutput("a5_rx_data", 32'(rx_data), 32'hA5);
      checkOutput("a5_frame_err_count", 32'(frameErrCnt), 32'd0);
      checkOutput("a5_busy_after", 32'(busy), 32'h0);
      checkOutput("a5_done_latency", 32'(doneCyc - startCyc), 32'd154);

      $display("[TB] sparse ticks, 0x3C then 0xFF back-to-back");
      tickPeriod = 4;
      applyStimulus(8'h3C, 1'b1, 64);
      checkOutput("3c_done_count", 32'(doneCnt), 32'd2);
      checkOutput("3c_rx_data", 32'(rx_data), 32'h3C);
      second = 8'hFF;
      sendBit(1'b0, 64);
      for (int i = 0; i < 5; i++) sendBit(second[i], 64);
      checkOutput("3c_held_mid_next", 32'(rx_data), 32'h3C);
      for (int i = 5; i < 8; i++) sendBit(second[i], 64);
      sendBit(1'b1, 64);
      sendBit(1'b1, 64);
      checkOutput("ff_done_count", 32'(doneCnt), 32'd3);
      checkOutput("ff_rx_data", 32'(rx_data), 32'hFF);

      $display("[TB] glitch on the line");
      tickPeriod = 1;
      sendBit(1'b1, 8);
      sendBit(1'b0, 4);
      checkOutput("glitch_busy_high", 32'(busy), 32'h1);
      sendBit(1'b1, 40);
      checkOutput("glitch_busy_low", 32'(busy), 32'h0);
      checkOutput("glitch_done_count", 32'(doneCnt), 32'd3);
      checkOutput("glitch_frame_err_count", 32'(frameErrCnt), 32'd0);
      checkOutput("glitch_rx_data", 32'(rx_data), 32'hFF);

      $display("[TB] framing error on 0x55, line held low");
      applyStimulus(8'h55, 1'b0, 16);
      sendBit(1'b0, 48);
      checkOutput("ferr_busy_in_break", 32'(busy), 32'h1);
      checkOutput("ferr_frame_err_count", 32'(frameErrCnt), 32'd1);
      checkOutput("ferr_done_count", 32'(doneCnt), 32'd3);
      checkOutput("ferr_rx_data_kept", 32'(rx_data), 32'hFF);
      sendBit(1'b1, 32);
      checkOutput("ferr_busy_released", 32'(busy), 32'h0);
      applyStimulus(8'h81, 1'b1, 16);
      sendBit(1'b1, 16);
      checkOutput("81_rx_data", 32'(rx_data), 32'h81);
      checkOutput("81_done_count", 32'(doneCnt), 32'd4);
      checkOutput("81_frame_err_count", 32'(frameErrCnt), 32'd1);

      $display("[TB] reset in the middle of 0xF0");
      sendBit(1'b0, 16);
      for (int i = 0; i < 4; i++) sendBit(8'hF0 >> i, 16);
      n_rst = 1'b0;
      #1;
      checkOutput("rst_mid_rx_data", 32'(rx_data), 32'h0);
      checkOutput("rst_mid_busy", 32'(busy), 32'h0);
      checkOutput("rst_mid_rx_done", 32'(rx_done), 32'h0);
      checkOutput("rst_mid_frame_err", 32'(frame_err), 32'h0);
      rxd = 1'b1;
      @(negedge clk);
      n_rst = 1'b1;
      repeat (16) @(negedge clk);
      applyStimulus(8'h0F, 1'b1, 16);
      sendBit(1'b1, 16);
      checkOutput("0f_rx_data", 32'(rx_data), 32'h0F);
      checkOutput("0f_done_count", 32'(doneCnt), 32'd5);

      $display("[TB] rxen gated low for 20 clk inside bit 3 of 0x96");
      gated = 8'h96;
      sendBit(1'b0, 16);
      for (int i = 0; i < 3; i++) sendBit(gated[i], 16);
      sendBit(gated[3], 8);
      rxenGate = 1'b0;
      repeat (20) @(negedge clk);
      rxenGate = 1'b1;
      repeat (8) @(negedge clk);
      for (int i = 4; i < 8; i++) sendBit(gated[i], 16);
      sendBit(1'b1, 16);
      sendBit(1'b1, 16);
      checkOutput("96_rx_data", 32'(rx_data), 32'h96);
      checkOutput("96_done_count", 32'(doneCnt), 32'd6);
      checkOutput("done_and_ferr_never_both", 32'(bothHigh), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver. It is the receive-side counterpart of the team's 8N1 transmitter: 1 start bit (0), 8 data bits sent LSB first, 1 stop bit (1), line idle high.
- It samples the asynchronous serial input `rxd` through a 2-flop synchronizer, using an oversampling enable tick from the shared baud generator.
- It delivers each byte in parallel with a one-cycle `rx_done` strobe, and flags framing errors and false starts.

Parameters:
- OVS, 16, oversampling ticks per bit (even, 4..16).
- DBITS, 8, data bits per frame (5..8).

Ports:
- clk  input  1  system clock; all logic on posedge.
- n_rst  input  1  asynchronous active-low reset.
- rxd  input  1  serial line, asynchronous to clk; idle high.
- rxen  input  1  oversample tick, one-cycle pulse, OVS pulses per bit time.
- rx_data  output  DBITS  last received byte; held until the next byte completes.
- rx_done  output  1  one-cycle pulse when a byte with a valid stop bit lands in rx_data.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, n_rst=0):
  - state=IDLE; synchronizer flops=1; tick_cnt=0; bit_cnt=0; shift=0.
  - rx_data=0, rx_done=0, frame_err=0, busy=0.
- Synchronizer: `rxs` is `rxd` delayed by 2 clk flops. All decisions use `rxs` only.
- Counting rules:
  - tick_cnt (width clog2(OVS)) and bit_cnt advance only on cycles with rxen=1.
  - With rxen=0, every state, counter and shift register holds.
- State machine, all transitions on rxen=1 cycles only:
  - IDLE: if rxs==0, go to START with tick_cnt=0. Otherwise stay.
  - START: tick_cnt increments.
    - At tick_cnt==OVS/2-1 (mid start bit), sample rxs.
    - rxs==0: go to DATA with tick_cnt=0, bit_cnt=0.
    - rxs==1: false start. Return to IDLE with no outputs pulsed.
  - DATA: tick_cnt increments.
    - At tick_cnt==OVS-1: shift <= {rxs, shift[DBITS-1:1]}, tick_cnt=0, bit_cnt++.
    - When the DBITS-th bit is captured, go to STOP.
  - STOP: tick_cnt increments. At tick_cnt==OVS-1, sample rxs.
    - rxs==1: rx_data <= shift, rx_done=1 for one cycle, go to IDLE.
    - rxs==0: frame_err=1 for one cycle, rx_data unchanged, go to BRK.
  - BRK: wait for rxs==1 on an rxen tick, then go to IDLE. This prevents a held-low line from re-triggering START.
- Sample timing (t0 = the rxen tick at which IDLE sees rxs==0):
  - Start midpoint is t0+OVS/2-1.
  - Data bit k (k=0..DBITS-1) is sampled at t0+OVS/2-1+OVS*(k+1).
  - Stop bit is sampled at t0+OVS/2-1+OVS*(DBITS+1).
- Latency: rx_done or frame_err is registered and asserted in the clk cycle after the stop-sample tick. Both are 0 on every other cycle.
- Outputs:
  - rx_done and frame_err are never high in the same cycle.
  - busy is registered and tracks state != IDLE.
- Back-to-back frames: after a good stop sample, IDLE can detect the next start on the very next rxen tick. No dead time beyond that.
- Reset mid-frame: aborts immediately. No rx_done or frame_err pulse. rx_data returns to 0.
- Illegal state encodings recover to IDLE on the next clk.

Test Plan:
- Single byte: OVS=16, rxen every clk; serialize 0xA5 at 16 clk/bit -> exactly one rx_done pulse, rx_data=0xA5, frame_err never high, busy low after the stop sample.
- Sparse tick: rxen every 4th clk, 64 clk/bit; send 0x3C then 0xFF back-to-back -> two rx_done pulses; rx_data=0x3C after the first and 0xFF after the second; rx_data stable between frames.
- Glitch: drive rxd low for 4 oversample ticks, then high -> busy pulses high, returns to IDLE, no rx_done, no frame_err, rx_data unchanged.
- Framing error: send 0x55 with the stop bit driven 0, then hold the line low for 3 bit times, then high -> one frame_err pulse, no rx_done, rx_data keeps its previous value, no new START until the line returns high; a following 0x81 then receives correctly.
- Reset mid-frame: assert n_rst low after 4 data bits of 0xF0 -> all outputs 0 asynchronously; after release, a fresh 0x0F frame yields rx_data=0x0F with one rx_done.
- Tick gating: send 0x96 with rxen held low for 20 clk in the middle of bit 3, and the bit stretched accordingly -> rx_data=0x96, proving state holds while rxen=0.
